// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator: state encoding,
// default geometry and a constant-evaluable clog2.
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_MAX_OPS = 16;
  localparam int DEF_CHUNK   = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Bitwise 3:2 compressor. cout is the unshifted majority vector; the caller
// aligns it to the next bit position.
module csa_3to2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Multi-operand adder: folds a valid/ready operand stream into redundant
// sum/carry registers, then resolves them CHUNK bits per cycle.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_OPS = DEF_MAX_OPS,
  parameter int CHUNK   = DEF_CHUNK,
  localparam int CNT_W  = clog2(MAX_OPS),
  localparam int ACC_W  = WIDTH + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W:0]   out_count,
  output logic             out_ovf
);

  localparam int NCHUNK = ACC_W / CHUNK;
  localparam int IDX_W  = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;
  localparam logic [CNT_W:0]   CNT_MAX  = (CNT_W+1)'(MAX_OPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [ACC_W-1:0] CH_MASK  = ACC_W'({CHUNK{1'b1}});

  state_e           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [ACC_W-1:0] c_q, c_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] chunk_q, chunk_d;
  logic             cy_q, cy_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] csa_s;
  logic [ACC_W-1:0] csa_maj;
  logic [ACC_W-1:0] s_sh, c_sh;
  logic [CHUNK:0]   chunk_sum;

  assign din_ext = {{CNT_W{1'b0}}, in_data};

  csa_3to2 #(.W(ACC_W)) u_csa (
    .a    (s_q),
    .b    (c_q),
    .c    (din_ext),
    .s    (csa_s),
    .cout (csa_maj)
  );

  // Current chunk pulled down to bit 0; carry-in is the previous chunk's carry-out.
  assign s_sh      = s_q >> (chunk_q * CHUNK);
  assign c_sh      = c_q >> (chunk_q * CHUNK);
  assign chunk_sum = {1'b0, s_sh[CHUNK-1:0]} + {1'b0, c_sh[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, cy_q};

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    chunk_d     = chunk_q;
    cy_d        = cy_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          s_d = csa_s;
          c_d = {csa_maj[ACC_W-2:0], 1'b0};
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + 1'b1;
          if (in_last) begin
            state_d = RESOLVE;
            chunk_d = '0;
            cy_d    = 1'b0;
          end
        end
      end
      RESOLVE: begin
        res_d = (res_q & ~(CH_MASK << (chunk_q * CHUNK)))
              | (ACC_W'(chunk_sum[CHUNK-1:0]) << (chunk_q * CHUNK));
        cy_d  = chunk_sum[CHUNK];
        if (chunk_q == LAST_IDX) begin
          state_d = DONE;
          chunk_d = '0;
        end else begin
          chunk_d = chunk_q + IDX_ONE;
        end
      end
      DONE: begin
        // out_valid trails DONE entry by one cycle so the result is registered
        // before it is offered.
        if (out_valid_q && out_ready) begin
          s_d         = '0;
          c_d         = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      chunk_q     <= '0;
      cy_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      chunk_q     <= chunk_d;
      cy_q        <= cy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_sum   = res_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator at default parameters (ACC_W=20, NCHUNK=5).
module tb_csa_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_sum;
  logic [4:0]  out_count;
  logic        out_ovf;

  int passed;
  int total;

  csa_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send_beat(input logic [15:0] d, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count rising edges until out_valid is seen (bounded).
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic handshake;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== {1'b1, 1'b0, 20'h0, 5'd0, 1'b0})
      $display("FAIL reset: rdy=%0b vld=%0b sum=%h cnt=%0d ovf=%0b, required 1 0 00000 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    else passed++;
  endtask

  task automatic test_basic;
    int n;
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b0);
    send_beat(16'h0003, 1'b1);
    total++;
    if (in_ready !== 1'b0) $display("FAIL basic_busy: in_ready=%0b, required 0", in_ready);
    else passed++;
    wait_out(n);
    total++;
    if (n !== 6) $display("FAIL basic_latency: %0d cycles, required 6", n);
    else passed++;
    total++;
    if ({out_sum, out_count, out_ovf} !== {20'h00006, 5'd3, 1'b0})
      $display("FAIL basic_result: sum=%h cnt=%0d ovf=%0b, required 00006 3 0", out_sum, out_count, out_ovf);
    else passed++;
    handshake();
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL basic_release: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_full_packet;
    int n;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(16'hFFFF, (i == 15));
    end
    wait_out(n);
    total++;
    if (!out_valid) $display("FAIL full_timeout: out_valid=%0b, required 1", out_valid);
    else passed++;
    total++;
    if ({out_sum, out_count, out_ovf} !== {20'hFFFF0, 5'd16, 1'b0})
      $display("FAIL full_result: sum=%h cnt=%0d ovf=%0b, required ffff0 16 0", out_sum, out_count, out_ovf);
    else passed++;
    handshake();
  endtask

  task automatic test_overflow;
    int n;
    for (int i = 0; i < 17; i++) send_beat(16'hFFFF, (i == 16));
    wait_out(n);
    total++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, 20'h0FFEF, 5'd16, 1'b1})
      $display("FAIL ovf_result: vld=%0b sum=%h cnt=%0d ovf=%0b, required 1 0ffef 16 1",
               out_valid, out_sum, out_count, out_ovf);
    else passed++;
    handshake();
    total++;
    if ({out_count, out_ovf} !== {5'd0, 1'b0})
      $display("FAIL ovf_clear: cnt=%0d ovf=%0b, required 0 0", out_count, out_ovf);
    else passed++;
  endtask

  task automatic test_backpressure;
    int n;
    int bad;
    send_beat(16'h8000, 1'b1);
    wait_out(n);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_sum !== 20'h08000 || out_count !== 5'd1 || in_ready !== 1'b0)
        bad++;
    end
    total++;
    if (bad !== 0)
      $display("FAIL hold_stable: %0d bad cycles (last vld=%0b sum=%h rdy=%0b), required 0",
               bad, out_valid, out_sum, in_ready);
    else passed++;
    handshake();
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL hold_release: vld=%0b rdy=%0b, required 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_resolve;
    int n;
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b0);
    send_beat(16'h0003, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, out_sum, out_count, out_ovf} !== {1'b1, 1'b0, 20'h0, 5'd0, 1'b0})
      $display("FAIL midrst_state: rdy=%0b vld=%0b sum=%h cnt=%0d ovf=%0b, required 1 0 00000 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    else passed++;
    repeat (8) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL midrst_quiet: out_valid=%0b, required 0", out_valid);
    else passed++;
    send_beat(16'h0005, 1'b1);
    wait_out(n);
    total++;
    if ({out_valid, out_sum, out_count, out_ovf} !== {1'b1, 20'h00005, 5'd1, 1'b0})
      $display("FAIL midrst_packet: vld=%0b sum=%h cnt=%0d ovf=%0b, required 1 00005 1 0",
               out_valid, out_sum, out_count, out_ovf);
    else passed++;
    handshake();
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_full_packet();
    test_overflow();
    test_backpressure();
    test_reset_mid_resolve();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
